// File: rtl/bin_bbox_tracker_pkg.sv
// rtl/bin_bbox_tracker_pkg.sv - shared image defaults and FSM encodings for the bbox tracker
//
// Purpose : default frame geometry and the tracker FSM state type, shared with
//           the overlay block that reuses px_xy_counter.
// Ports   : none (package).

package bin_bbox_tracker_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/bin_bbox_tracker_xy.sv
// rtl/bin_bbox_tracker_xy.sv - raster position counter for a sop-framed pixel stream
//
// Purpose : reports the (x,y) coordinate of the current beat. The sop beat is
//           (0,0); x wraps after IMG_W-1 and bumps y; y saturates at IMG_H-1
//           and raises a sticky overrun flag (cleared by the next sop).
// Ports   : clk, rst_n      - clock, async active-low reset
//           sop, vld        - start-of-frame marker and beat qualifier
//           x, y            - coordinate of the beat presented this cycle
//           eol             - valid beat sitting on the last column
//           overrun         - frame already ran past the last line

module px_xy_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sop,
  input  logic          vld,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          eol,
  output logic          overrun
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // Registers hold the position the *next* beat will take; sop overrides
  // them combinationally so the sop beat itself is always (0,0).
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          ovr_q;

  assign x       = sop ? '0   : x_q;
  assign y       = sop ? '0   : y_q;
  assign overrun = sop ? 1'b0 : ovr_q;
  assign eol     = vld && (x == X_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      ovr_q <= 1'b0;
    end else if (vld) begin
      x_q   <= eol ? '0 : x + 1'b1;
      y_q   <= (eol && (y != Y_LAST)) ? y + 1'b1 : y;
      ovr_q <= overrun | (eol && (y == Y_LAST));
    end
  end

endmodule

// File: rtl/bin_bbox_tracker.sv
// rtl/bin_bbox_tracker.sv - per-frame bounding box and hit count of a binary pixel stream
//
// Purpose : accumulates min/max x/y and the saturating count of '1' pixels in
//           each frame and publishes one registered result per frame.
// Ports   : clk, rst_n                 - pixel clock, async active-low reset
//           din_sop/din_eop/din_vld    - frame markers and beat qualifier
//           din                        - binary pixel, 1 = hit
//           x_min/x_max/y_min/y_max    - published box (0 when no hits)
//           pix_cnt, box_found         - published hit count, count >= MIN_PIX
//           box_valid                  - 1-cycle pulse, results updated
//           frame_err                  - 1-cycle pulse, malformed or restarted frame

module bin_bbox_tracker
  import bin_bbox_tracker_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int CW      = 19,
  parameter int MIN_PIX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic          din_vld,
  input  logic          din,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] pix_cnt,
  output logic          box_found,
  output logic          box_valid,
  output logic          frame_err
);

  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t state_q, state_d;

  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          cur_eol, cur_ovr;

  logic [XW-1:0] xmin_q, xmax_q, xmin_d, xmax_d;
  logic [YW-1:0] ymin_q, ymax_q, ymin_d, ymax_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic acc_en, frame_end, restart_err, well_formed;

  px_xy_counter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW)
  ) u_xy (
    .clk     (clk),
    .rst_n   (rst_n),
    .sop     (din_sop),
    .vld     (din_vld),
    .x       (cur_x),
    .y       (cur_y),
    .eol     (cur_eol),
    .overrun (cur_ovr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Results are registered on the edge that samples the eop beat, so they are
  // visible during the DONE cycle. DONE therefore accepts a new sop exactly
  // like IDLE: the accumulators are free to restart without racing the publish.
  always_comb begin
    state_d     = state_q;
    acc_en      = 1'b0;
    frame_end   = 1'b0;
    restart_err = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (din_vld && din_sop) begin
          acc_en    = 1'b1;
          frame_end = din_eop;
          state_d   = din_eop ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (din_vld) begin
          acc_en      = 1'b1;
          restart_err = din_sop;
          if (din_eop) begin
            frame_end = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator update for the current beat; sop substitutes fresh seeds
  // before the sop pixel itself is applied.
  always_comb begin
    xmin_d = din_sop ? '1 : xmin_q;
    xmax_d = din_sop ? '0 : xmax_q;
    ymin_d = din_sop ? '1 : ymin_q;
    ymax_d = din_sop ? '0 : ymax_q;
    cnt_d  = din_sop ? '0 : cnt_q;
    if (din) begin
      if (cur_x < xmin_d) xmin_d = cur_x;
      if (cur_x > xmax_d) xmax_d = cur_x;
      if (cur_y < ymin_d) ymin_d = cur_y;
      if (cur_y > ymax_d) ymax_d = cur_y;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
    end
  end

  assign well_formed = cur_eol && (cur_y == Y_LAST) && !cur_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else if (acc_en) begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      pix_cnt   <= '0;
      box_found <= 1'b0;
      box_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      box_valid <= frame_end && well_formed;
      frame_err <= restart_err || (frame_end && !well_formed);
      if (frame_end && well_formed) begin
        // An empty frame would otherwise publish the all-ones min seeds.
        x_min     <= (cnt_d == '0) ? '0 : xmin_d;
        x_max     <= (cnt_d == '0) ? '0 : xmax_d;
        y_min     <= (cnt_d == '0) ? '0 : ymin_d;
        y_max     <= (cnt_d == '0) ? '0 : ymax_d;
        pix_cnt   <= cnt_d;
        box_found <= (cnt_d >= CW'(MIN_PIX));
      end
    end
  end

endmodule

// File: tb/tb_bin_bbox_tracker.sv
// tb/tb_bin_bbox_tracker.sv - scoreboard bench for bin_bbox_tracker on a reduced 32x24 frame

module tb_bin_bbox_tracker;

  localparam int IMG_W   = 32;
  localparam int IMG_H   = 24;
  localparam int XW      = 5;
  localparam int YW      = 5;
  localparam int CW      = 6;
  localparam int MIN_PIX = 40;
  localparam int NPIX    = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_sop = 1'b0, din_eop = 1'b0, din_vld = 1'b0, din = 1'b0;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;
  logic [CW-1:0] pix_cnt;
  logic box_found, box_valid, frame_err;

  always #5 clk = ~clk;

  bin_bbox_tracker #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW), .CW(CW), .MIN_PIX(MIN_PIX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld), .din(din),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .pix_cnt(pix_cnt), .box_found(box_found),
    .box_valid(box_valid), .frame_err(frame_err)
  );

  typedef struct {
    bit is_err;
    int xmn, xmx, ymn, ymx, cnt, fnd;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_valid(input int xmn, xmx, ymn, ymx, cnt, fnd);
    exp_t e;
    e.is_err = 1'b0;
    e.xmn = xmn; e.xmx = xmx; e.ymn = ymn; e.ymx = ymx; e.cnt = cnt; e.fnd = fnd;
    last = e;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = last;
    e.is_err = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input bit d);
    din_vld = v; din_sop = s; din_eop = e; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic bit hit(input int pat, input int x, input int y);
    case (pat)
      1: return (x == 10) && (y == 5);
      2: return (x >= 20) && (x <= 27) && (y >= 10) && (y <= 14);
      3: return 1'b1;
      4: return (x >= 20) && (x <= 27) && (y >= 10) && (y <= 14) && !((x == 27) && (y == 14));
      default: return 1'b0;
    endcase
  endfunction

  // Beats 0..total-1; a second sop at restart_at (if >= 0) switches to post_pat
  // with coordinates restarting from (0,0). Gap cycles carry junk with vld=0.
  task automatic send_frame(input int pre_pat, input int post_pat, input int total,
                            input int restart_at, input int gap_pct, input bit with_eop);
    for (int b = 0; b < total; b++) begin
      int p;
      int pat;
      bit s;
      if (restart_at >= 0 && b >= restart_at) begin
        p = b - restart_at; pat = post_pat;
      end else begin
        p = b; pat = pre_pat;
      end
      s = (b == 0) || (b == restart_at);
      while (int'($urandom_range(99)) < gap_pct)
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      drive(1'b1, s, with_eop && (b == total - 1), hit(pat, p % IMG_W, p / IMG_W));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x_min"}, int'(x_min), 0);
    chk({tag, "_x_max"}, int'(x_max), 0);
    chk({tag, "_y_min"}, int'(y_min), 0);
    chk({tag, "_y_max"}, int'(y_max), 0);
    chk({tag, "_pix_cnt"}, int'(pix_cnt), 0);
    chk({tag, "_box_found"}, int'(box_found), 0);
    chk({tag, "_box_valid"}, int'(box_valid), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  // Monitor: every result/error pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (box_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'({box_valid, frame_err}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", int'({box_valid, frame_err}), e.is_err ? 1 : 2);
          chk("x_min", int'(x_min), e.xmn);
          chk("x_max", int'(x_max), e.xmx);
          chk("y_min", int'(y_min), e.ymn);
          chk("y_max", int'(y_max), e.ymx);
          chk("pix_cnt", int'(pix_cnt), e.cnt);
          chk("box_found", int'(box_found), e.fnd);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    last = '{is_err: 1'b0, xmn: 0, xmx: 0, ymn: 0, ymx: 0, cnt: 0, fnd: 0};
    #1;
    chk_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single hit, then a block frame whose sop lands in the DONE cycle.
    push_valid(10, 10, 5, 5, 1, 0);
    send_frame(1, 1, NPIX, -1, 0, 1'b1);
    push_valid(20, 27, 10, 14, 40, 1);
    send_frame(2, 2, NPIX, -1, 0, 1'b1);
    idle(4);

    // Empty frame with ~30% idle cycles.
    push_valid(0, 0, 0, 0, 0, 0);
    send_frame(0, 0, NPIX, -1, 30, 1'b1);
    idle(4);

    // One hit below the MIN_PIX threshold.
    push_valid(20, 27, 10, 14, 39, 0);
    send_frame(4, 4, NPIX, -1, 0, 1'b1);
    idle(4);

    // Short frame, overrun frame, single-beat sop+eop frame: all malformed.
    push_err();
    send_frame(3, 3, 101, -1, 0, 1'b1);
    idle(4);
    push_err();
    send_frame(0, 0, NPIX + IMG_W, -1, 10, 1'b1);
    idle(4);
    push_err();
    send_frame(3, 3, 1, -1, 0, 1'b1);
    idle(4);

    // Restart at beat 500 of an all-ones frame; only the block must count.
    push_err();
    push_valid(20, 27, 10, 14, 40, 1);
    send_frame(3, 2, 500 + NPIX, 500, 0, 1'b1);
    idle(4);

    // Reset mid-frame, stray eop, then a saturating all-ones frame.
    send_frame(3, 3, 200, -1, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    last = '{is_err: 1'b0, xmn: 0, xmx: 0, ymn: 0, ymx: 0, cnt: 0, fnd: 0};
    idle(2);
    rst_n = 1'b1;
    idle(2);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
    push_valid(0, IMG_W - 1, 0, IMG_H - 1, 63, 1);
    send_frame(3, 3, NPIX, -1, 20, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
